// File: rtl/globals_sv.sv
// globals_sv: shared NPU datapath widths and the loop-nest sequencer types.
// Contents: datapath width constants, the sequencer state encoding, the
// number of loop levels, and a helper that builds the active PE-row mask.
package globals_sv;

  localparam int W           = 8;  // PE rows
  localparam int CLOG2K      = 4;  // kernel-loop index width
  localparam int CLOG2W      = 3;  // PE-row index width
  localparam int CLOG2L      = 4;  // outer loop index width
  localparam int NB_LOOP_LVL = 6;  // KSI plus L0..L4

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t;

  // Bits [ckg:0] set, all higher bits clear.
  function automatic logic [W-1:0] row_mask(input logic [CLOG2W-1:0] ckg);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      m[i] = (i <= int'(ckg));
    end
    return m;
  endfunction

endpackage

// File: rtl/loop_lvl_cnt.sv
// loop_lvl_cnt: one level of the loop-nest odometer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - latch bound and restart the index at 0
//   en        - advance this level by one
//   bound     - loop count minus 1, captured on clr
//   idx       - current index (registered)
//   last      - idx equals the latched bound (registered); doubles as carry
module loop_lvl_cnt
  import globals_sv::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] bound,
  output logic [WIDTH-1:0] idx,
  output logic             last
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bnd;
  logic [WIDTH-1:0] nxt;

  assign nxt = idx + ONE;

  // Index, latched bound and registered last flag; last is precomputed for
  // the value idx takes so that it is equality against the latched bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      bnd  <= '0;
      last <= 1'b0;
    end else if (clr) begin
      idx  <= '0;
      bnd  <= bound;
      last <= (bound == '0);
    end else if (en) begin
      if (last) begin
        idx  <= '0;
        last <= (bnd == '0);
      end else begin
        idx  <= nxt;
        last <= (nxt == bnd);
      end
    end
  end

endmodule

// File: rtl/loop_seq.sv
// loop_seq: six-level loop-nest sequencer (KSI innermost, L4 outermost).
// Latches arv_* bounds on start and issues one step per loop iteration over a
// valid/ready handshake, with per-level indices, last flags and a PE-row mask.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   arv_KSI, arv_CKG, arv_L0..arv_L4 - loop bounds (count minus 1), sampled on start
//   start                     - launch request, honoured only in IDLE
//   busy                      - high in RUN and DONE
//   step_valid / step_ready   - step handshake
//   done                      - one-cycle pulse after the final step
//   idx_k, idx_l0..idx_l4     - per-level indices
//   last_k, last_l0..last_l4  - per-level last flags (0 when no step shown)
//   row_en                    - active PE-row mask
// Build option LOOP_SEQ_PERF_EN adds perf_stall, a saturating count of
// cycles with step_valid && !step_ready, cleared on an accepted start.
module loop_seq
  import globals_sv::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CLOG2K-1:0] arv_KSI,
  input  logic [CLOG2W-1:0] arv_CKG,
  input  logic [CLOG2L-1:0] arv_L0,
  input  logic [CLOG2L-1:0] arv_L1,
  input  logic [CLOG2L-1:0] arv_L2,
  input  logic [CLOG2L-1:0] arv_L3,
  input  logic [CLOG2L-1:0] arv_L4,
  input  logic              start,
  output logic              busy,
  output logic              step_valid,
  input  logic              step_ready,
  output logic              done,
  output logic [CLOG2K-1:0] idx_k,
  output logic [CLOG2L-1:0] idx_l0,
  output logic [CLOG2L-1:0] idx_l1,
  output logic [CLOG2L-1:0] idx_l2,
  output logic [CLOG2L-1:0] idx_l3,
  output logic [CLOG2L-1:0] idx_l4,
  output logic              last_k,
  output logic              last_l0,
  output logic              last_l1,
  output logic              last_l2,
  output logic              last_l3,
  output logic              last_l4,
  output logic [W-1:0]      row_en
`ifdef LOOP_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall
`endif
);

  seq_state_t               state;
  logic                     launch;
  logic                     fire;
  logic                     all_last;
  logic [NB_LOOP_LVL-1:0]   lvl_last;
  logic [NB_LOOP_LVL-1:0]   lvl_en;
  logic [CLOG2L-1:0]        l_bound [5];
  logic [CLOG2L-1:0]        l_idx   [5];

  assign launch   = (state == SEQ_IDLE) && start;
  assign fire     = step_valid && step_ready;
  assign all_last = &lvl_last;

  // Carry chain: a level advances when a step fires and every inner level
  // is at its bound. The final step advances nothing so indices hold.
  always_comb begin
    logic carry;
    carry = fire && !all_last;
    for (int i = 0; i < NB_LOOP_LVL; i++) begin
      lvl_en[i] = carry;
      carry     = carry && lvl_last[i];
    end
  end

  loop_lvl_cnt #(.WIDTH(CLOG2K)) u_cnt_k (
    .clk   (clk),
    .rst   (rst),
    .clr   (launch),
    .en    (lvl_en[0]),
    .bound (arv_KSI),
    .idx   (idx_k),
    .last  (lvl_last[0])
  );

  assign l_bound[0] = arv_L0;
  assign l_bound[1] = arv_L1;
  assign l_bound[2] = arv_L2;
  assign l_bound[3] = arv_L3;
  assign l_bound[4] = arv_L4;

  for (genvar g = 0; g < 5; g++) begin : g_lvl
    loop_lvl_cnt #(.WIDTH(CLOG2L)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (launch),
      .en    (lvl_en[g+1]),
      .bound (l_bound[g]),
      .idx   (l_idx[g]),
      .last  (lvl_last[g+1])
    );
  end

  assign idx_l0 = l_idx[0];
  assign idx_l1 = l_idx[1];
  assign idx_l2 = l_idx[2];
  assign idx_l3 = l_idx[3];
  assign idx_l4 = l_idx[4];

  // Last flags are only meaningful while a step is shown.
  assign last_k  = lvl_last[0] && step_valid;
  assign last_l0 = lvl_last[1] && step_valid;
  assign last_l1 = lvl_last[2] && step_valid;
  assign last_l2 = lvl_last[3] && step_valid;
  assign last_l3 = lvl_last[4] && step_valid;
  assign last_l4 = lvl_last[5] && step_valid;

  // Sequencer FSM with registered busy/step_valid/done/row_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEQ_IDLE;
      busy       <= 1'b0;
      step_valid <= 1'b0;
      done       <= 1'b0;
      row_en     <= '0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SEQ_RUN;
            busy       <= 1'b1;
            step_valid <= 1'b1;
            row_en     <= row_mask(arv_CKG);
          end
        end
        SEQ_RUN: begin
          if (fire && all_last) begin
            state      <= SEQ_DONE;
            step_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        SEQ_DONE: begin
          state <= SEQ_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state      <= SEQ_IDLE;
          busy       <= 1'b0;
          step_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOOP_SEQ_PERF_EN
  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= 32'd0;
    end else if (launch) begin
      perf_stall <= 32'd0;
    end else if (step_valid && !step_ready && (perf_stall != 32'hFFFF_FFFF)) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
